// File: rtl/mor1kx_stage_queue_cappuccino.sv
// Execute-to-ctrl stage buffer: holds up to DEPTH in-flight instructions between execute and ctrl.
// Latency: 1 cycle from push to head visibility; write-back strobe 1 cycle after retirement.
// Backpressure: in_ready_o drops when full unless the head retires this cycle; a flush clears the queue in one cycle.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush_i                  discard all queued entries (a same-cycle push survives)
//   in_*                     execute-side handshake and instruction payload
//   out_*                    ctrl-side view of the head entry and retire handshake
//   long_ack_i               completion of the head long operation (load, mfspr)
//   wb_rf_wb_o, wb_rfd_adr_o registered write-back strobe and address
//   count_o                  occupancy

`ifndef OR1K_RESET_VECTOR
`define OR1K_RESET_VECTOR 5'h01
`endif

module mor1kx_stage_queue_cappuccino #(
    parameter OPTION_OPERAND_WIDTH = 32,
    parameter OPTION_RF_ADDR_WIDTH = 5,
    parameter [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
        {{(OPTION_OPERAND_WIDTH-13){1'b0}}, `OR1K_RESET_VECTOR, 8'd0},
    parameter DEPTH        = 2,
    parameter EXCEPT_WIDTH = 11,
    localparam CW          = $clog2(DEPTH+1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,

    input  logic                            in_valid_i,
    input  logic                            in_bubble_i,
    output logic                            in_ready_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] in_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] in_result_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] in_rfd_adr_i,
    input  logic                            in_rf_wb_i,
    input  logic                            in_long_op_i,
    input  logic [EXCEPT_WIDTH-1:0]         in_except_i,

    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] out_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] out_result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] out_rfd_adr_o,
    output logic                            out_rf_wb_o,
    output logic                            out_long_op_o,
    output logic [EXCEPT_WIDTH-1:0]         out_except_o,

    input  logic                            long_ack_i,

    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [CW-1:0]                   count_o
);

    // A single-entry queue still needs a 1-bit pointer; it simply never moves.
    localparam PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [OPTION_OPERAND_WIDTH-1:0] pc;
        logic [OPTION_OPERAND_WIDTH-1:0] result;
        logic [OPTION_RF_ADDR_WIDTH-1:0] rfd;
        logic                            rf_wb;
        logic                            long_op;
        logic [EXCEPT_WIDTH-1:0]         except;
    } entry_t;

    entry_t                          mem [DEPTH];
    entry_t                          head;
    entry_t                          in_entry;
    logic [PW-1:0]                   rd_ptr;
    logic [PW-1:0]                   wr_ptr;
    logic [CW-1:0]                   count;
    logic                            acked;
    logic [OPTION_OPERAND_WIDTH-1:0] last_pc;
    logic                            push;
    logic                            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign head = mem[rd_ptr];

    assign in_entry.pc      = in_pc_i;
    assign in_entry.result  = in_result_i;
    assign in_entry.rfd     = in_rfd_adr_i;
    assign in_entry.rf_wb   = in_rf_wb_i;
    assign in_entry.long_op = in_long_op_i;
    assign in_entry.except  = in_except_i;

    // Head outputs are gated while empty so unreset payload storage never leaks out.
    assign out_valid_o   = (count != '0);
    assign out_pc_o      = out_valid_o ? head.pc : last_pc;
    assign out_result_o  = out_valid_o ? head.result : '0;
    assign out_rfd_adr_o = out_valid_o ? head.rfd : '0;
    assign out_except_o  = out_valid_o ? head.except : '0;
    // A faulting entry never issues its bus access, so it does not wait for an ack.
    assign out_long_op_o = out_valid_o & head.long_op & ~|head.except;
    // Once the long op has been acked ctrl has already written/bypassed the result.
    assign out_rf_wb_o   = out_valid_o & head.rf_wb & ~acked;

    assign pop        = out_valid_o & out_ready_i & (~out_long_op_o | long_ack_i | acked);
    assign in_ready_o = (count < CW'(DEPTH)) | pop;
    assign push       = in_valid_i & in_ready_o & ~in_bubble_i;

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            acked        <= 1'b0;
            last_pc      <= OPTION_RESET_PC;
            wb_rf_wb_o   <= 1'b0;
            wb_rfd_adr_o <= '0;
        end else begin
            if (flush_i) begin
                // A same-cycle push lands at wr_ptr, which becomes the new head.
                rd_ptr <= wr_ptr;
                count  <= push ? CW'(1) : '0;
                acked  <= 1'b0;
            end else begin
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
                // Acks against an empty queue belong to a flushed op and are dropped.
                if (pop)
                    acked <= 1'b0;
                else if (long_ack_i && out_valid_o)
                    acked <= 1'b1;
            end

            if (push)
                wr_ptr <= ptr_inc(wr_ptr);

            if (pop) begin
                last_pc      <= head.pc;
                wb_rfd_adr_o <= head.rfd;
            end
            wb_rf_wb_o <= pop & head.rf_wb & ~flush_i;
        end
    end

    assign count_o = count;

endmodule

// File: tb/tb_mor1kx_stage_queue_cappuccino.sv
module tb_mor1kx_stage_queue_cappuccino;

    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i, in_bubble_i, in_ready_o;
    logic [31:0] in_pc_i, in_result_i;
    logic [4:0]  in_rfd_adr_i;
    logic        in_rf_wb_i, in_long_op_i;
    logic [10:0] in_except_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_pc_o, out_result_o;
    logic [4:0]  out_rfd_adr_o;
    logic        out_rf_wb_o, out_long_op_o;
    logic [10:0] out_except_o;
    logic        long_ack_i;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic [1:0]  count_o;

    always #5 clk = ~clk;

    mor1kx_stage_queue_cappuccino #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_bubble_i(in_bubble_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_result_i(in_result_i), .in_rfd_adr_i(in_rfd_adr_i),
        .in_rf_wb_i(in_rf_wb_i), .in_long_op_i(in_long_op_i), .in_except_i(in_except_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_result_o(out_result_o), .out_rfd_adr_o(out_rfd_adr_o),
        .out_rf_wb_o(out_rf_wb_o), .out_long_op_o(out_long_op_o),
        .out_except_o(out_except_o), .long_ack_i(long_ack_i),
        .wb_rf_wb_o(wb_rf_wb_o), .wb_rfd_adr_o(wb_rfd_adr_o), .count_o(count_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rfd;
        logic        rfwb;
        logic        lng;
        logic [10:0] exc;
    } ent_t;

    // Scoreboard of entries expected in the queue, plus the head/write-back state.
    ent_t        sb[$];
    logic        m_acked;
    logic        m_wb;
    logic [4:0]  m_wbadr;
    logic [31:0] m_last_pc;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic b, input logic [31:0] pc,
                          input logic [4:0] rfd, input logic rfwb, input logic lng,
                          input logic [10:0] exc);
        in_valid_i   = v;
        in_bubble_i  = b;
        in_pc_i      = pc;
        in_result_i  = pc ^ 32'hA5A5_0000;
        in_rfd_adr_i = rfd;
        in_rf_wb_i   = rfwb;
        in_long_op_i = lng;
        in_except_i  = exc;
    endtask

    task automatic ctl(input logic rdy, input logic ack, input logic fl);
        out_ready_i = rdy;
        long_ack_i  = ack;
        flush_i     = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 11'h0);
    endtask

    // One clock: check the DUT against the scoreboard mid-cycle, then advance the model.
    task automatic step();
        logic exp_long, exp_pop, exp_ready, do_push;
        ent_t h, e;
        @(negedge clk);
        chk("count", count_o, sb.size());
        if (sb.size() > 0) begin
            h = sb[0];
            exp_long = h.lng && (h.exc == 11'h0);
            chk("out_valid", out_valid_o, 1'b1);
            chk("out_pc", out_pc_o, h.pc);
            chk("out_result", out_result_o, h.res);
            chk("out_rfd", out_rfd_adr_o, h.rfd);
            chk("out_except", out_except_o, h.exc);
            chk("out_long_op", out_long_op_o, exp_long);
            chk("out_rf_wb", out_rf_wb_o, h.rfwb && !m_acked);
        end else begin
            exp_long = 1'b0;
            chk("empty_valid", out_valid_o, 1'b0);
            chk("empty_rf_wb", out_rf_wb_o, 1'b0);
            chk("empty_pc", out_pc_o, m_last_pc);
        end
        exp_pop   = (sb.size() > 0) && out_ready_i && (!exp_long || long_ack_i || m_acked);
        exp_ready = (sb.size() < DEPTH) || exp_pop;
        chk("in_ready", in_ready_o, exp_ready);
        chk("wb_rf_wb", wb_rf_wb_o, m_wb);
        if (m_wb)
            chk("wb_rfd_adr", wb_rfd_adr_o, m_wbadr);
        do_push = in_valid_i && exp_ready && !in_bubble_i;
        e.pc = in_pc_i; e.res = in_result_i; e.rfd = in_rfd_adr_i;
        e.rfwb = in_rf_wb_i; e.lng = in_long_op_i; e.exc = in_except_i;
        @(posedge clk);
        m_wb = exp_pop && h.rfwb && !flush_i;
        if (flush_i || exp_pop)
            m_acked = 1'b0;
        else if (long_ack_i && sb.size() > 0)
            m_acked = 1'b1;
        if (exp_pop) begin
            m_wbadr   = h.rfd;
            m_last_pc = h.pc;
            void'(sb.pop_front());
        end
        if (flush_i)
            sb.delete();
        if (do_push)
            sb.push_back(e);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_acked   = 1'b0;
        m_wb      = 1'b0;
        m_wbadr   = 5'd0;
        m_last_pc = RESET_PC;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ctl(1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        chk("rst_count", count_o, 2'd0);
        chk("rst_pc", out_pc_o, RESET_PC);
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_wb", wb_rf_wb_o, 1'b0);
        chk("rst_wb_adr", wb_rfd_adr_o, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Three back-to-back pushes into a 2-deep queue with ctrl stalled.
        set_in(1'b1, 1'b0, 32'h10, 5'd1, 1'b1, 1'b0, 11'h0); step();
        set_in(1'b1, 1'b0, 32'h14, 5'd2, 1'b1, 1'b0, 11'h0); step();
        set_in(1'b1, 1'b0, 32'h18, 5'd3, 1'b1, 1'b0, 11'h0); step();
        chk("full_count", count_o, 2'd2);
        chk("full_ready", in_ready_o, 1'b0);
        step();
        ctl(1'b1, 1'b0, 1'b0); step();
        idle(); step(); step(); step();

        // Long op at head, acked while ctrl stalls, then retired.
        ctl(1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 32'h20, 5'd5, 1'b1, 1'b1, 11'h0); step();
        idle(); step(); step(); step();
        ctl(1'b0, 1'b1, 1'b0); step();
        ctl(1'b0, 1'b0, 1'b0); step();
        chk("acked_rf_wb", out_rf_wb_o, 1'b0);
        ctl(1'b1, 1'b0, 1'b0); step();
        chk("long_wb_pulse", wb_rf_wb_o, 1'b1);
        chk("long_wb_adr", wb_rfd_adr_o, 5'd5);
        step();
        chk("long_wb_once", wb_rf_wb_o, 1'b0);

        // Faulting long op retires without an ack.
        ctl(1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 32'h30, 5'd7, 1'b1, 1'b1, 11'h004); step();
        idle(); step();
        ctl(1'b1, 1'b0, 1'b0); step(); step();

        // Flush with a full queue and a simultaneous push.
        ctl(1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 32'h40, 5'd8, 1'b1, 1'b0, 11'h0); step();
        set_in(1'b1, 1'b0, 32'h44, 5'd9, 1'b1, 1'b0, 11'h0); step();
        set_in(1'b1, 1'b0, 32'h100, 5'd10, 1'b1, 1'b0, 11'h0);
        ctl(1'b1, 1'b0, 1'b1); step();
        idle(); ctl(1'b0, 1'b0, 1'b0); step();
        chk("flush_count", count_o, 2'd1);
        chk("flush_pc", out_pc_o, 32'h100);
        chk("flush_wb", wb_rf_wb_o, 1'b0);
        ctl(1'b1, 1'b0, 1'b0); step(); step();

        // Bubble into an empty queue after retiring pc 0x1FC.
        set_in(1'b1, 1'b0, 32'h1FC, 5'd11, 1'b0, 1'b0, 11'h0); step();
        idle(); step(); step();
        set_in(1'b1, 1'b1, 32'h200, 5'd12, 1'b1, 1'b0, 11'h0); step();
        idle(); step();
        chk("bubble_count", count_o, 2'd0);
        chk("bubble_pc", out_pc_o, 32'h1FC);

        // Asynchronous reset in the middle of a long op.
        ctl(1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 32'h50, 5'd13, 1'b1, 1'b1, 11'h0); step();
        idle(); step(); step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count_o, 2'd0);
        chk("arst_pc", out_pc_o, RESET_PC);
        chk("arst_valid", out_valid_o, 1'b0);
        chk("arst_rf_wb", out_rf_wb_o, 1'b0);
        chk("arst_wb", wb_rf_wb_o, 1'b0);
        chk("arst_wb_adr", wb_rfd_adr_o, 5'd0);
        chk("arst_ready", in_ready_o, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ctl(1'b0, 1'b1, 1'b0); step();
        ctl(1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 32'h60, 5'd14, 1'b1, 1'b1, 11'h0); step();
        idle(); step();
        chk("post_rst_rf_wb", out_rf_wb_o, 1'b1);
        ctl(1'b1, 1'b1, 1'b0); step();
        ctl(1'b0, 1'b0, 1'b0); step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
